// File: rtl/mem_map_ctrl.sv
// Address-decoding memory map controller: routes one CPU access at a time to one of
// NREG devices, inserting per-region wait states and flagging unmapped/read-only errors.
module mem_map_ctrl #(
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter int                      NREG        = 3,
    parameter logic [NREG*ADDR_W-1:0]  REGION_BASE = {32'h0000_0800, 32'h0000_0400, 32'h0000_0000},
    parameter logic [NREG*ADDR_W-1:0]  REGION_MASK = {32'hFFFF_FFF0, 32'hFFFF_FF80, 32'hFFFF_FC00},
    parameter logic [NREG-1:0]         REGION_RO   = 3'b010,
    parameter logic [NREG*4-1:0]       REGION_WAIT = {4'd2, 4'd1, 4'd0}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NREG-1:0]          sel,
    output logic                     dev_we,
    output logic [ADDR_W-1:0]        dev_addr,
    output logic [DATA_W-1:0]        dev_wdata,
    input  logic [NREG*DATA_W-1:0]   dev_rdata
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       region_q;
    logic                we_q;
    logic                err_q;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                hit;
    logic [RW-1:0]       hit_idx;
    logic                legal;

    // Scan from the top index down so the lowest matching region wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((req_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = i[RW-1:0];
            end
        end
        legal = hit && !(req_we && REGION_RO[hit_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            region_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    we_q     <= req_we;
                    wdata_q  <= req_wdata;
                    region_q <= hit_idx;
                    err_q    <= !legal;
                    cnt      <= legal ? REGION_WAIT[hit_idx*4 +: 4] : 4'd0;
                    rdata_q  <= '0;
                end
                ACCESS: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        rdata_q <= we_q ? '0 : dev_rdata[region_q*DATA_W +: DATA_W];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        sel       = '0;
        dev_we    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = legal ? ACCESS : RESP;
            end
            ACCESS: begin
                sel[region_q] = 1'b1;
                if (cnt == 4'd0) begin
                    dev_we    = we_q;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;

endmodule
